// File: rtl/timed_count_pkg.sv
// Shared types and constants for the timed-counter monitor slice.
package timed_count_pkg;

  localparam int CNT_WIDTH_DEF = 25;

  // Wide enough for any practical count width; truncated at the point of use.
  localparam logic [63:0] CNT_ALL_ONES = '1;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } avg_state_e;

endpackage

// File: rtl/count_boxcar_avg.sv
// Power-of-2 boxcar averager: window counter, accumulator and FILL/RUN state.
module count_boxcar_avg
  import timed_count_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int AVG_LOG2  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] count_in,
  input  logic                 count_valid_in,
  output logic [CNT_WIDTH-1:0] avg_count_o,
  output logic                 avg_valid_o
);

  // 2^AVG_LOG2 samples of CNT_WIDTH bits always fit without overflow.
  localparam int ACC_WIDTH = CNT_WIDTH + AVG_LOG2;

  avg_state_e           state_q, state_d;
  logic [AVG_LOG2-1:0]  win_cnt_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 win_done;

  assign acc_sum  = acc_q + ACC_WIDTH'(count_in);
  assign win_done = count_valid_in && (win_cnt_q == '1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    avg_valid_o = 1'b0;
    case (state_q)
      FILL:    if (win_done) state_d = RUN;
      RUN:     avg_valid_o = 1'b1;
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      win_cnt_q   <= '0;
      acc_q       <= '0;
      avg_count_o <= '0;
    end else begin
      state_q <= state_d;
      if (count_valid_in) begin
        win_cnt_q <= win_cnt_q + 1'b1;
        if (win_done) begin
          avg_count_o <= acc_sum[ACC_WIDTH-1:AVG_LOG2];
          acc_q       <= '0;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end

endmodule

// File: rtl/timed_count_monitor.sv
// Monitor for free-running interval counts: last/avg/peak, hysteretic alarm, read handshake.
// Optional min tracking is enabled by defining TIMED_COUNT_MONITOR_MIN_EN.
module timed_count_monitor
  import timed_count_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int AVG_LOG2  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] count_in,
  input  logic                 count_valid_in,
  input  logic [CNT_WIDTH-1:0] thresh_hi_in,
  input  logic [CNT_WIDTH-1:0] thresh_lo_in,
  input  logic                 rd_ack_in,
  output logic [CNT_WIDTH-1:0] last_count_o,
  output logic [CNT_WIDTH-1:0] avg_count_o,
  output logic                 avg_valid_o,
  output logic [CNT_WIDTH-1:0] max_count_o,
  output logic [CNT_WIDTH-1:0] min_count_o,
  output logic                 alarm_o,
  output logic                 new_data_o,
  output logic                 missed_o
);

  count_boxcar_avg #(
    .CNT_WIDTH(CNT_WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk           (clk),
    .rst           (rst),
    .count_in      (count_in),
    .count_valid_in(count_valid_in),
    .avg_count_o   (avg_count_o),
    .avg_valid_o   (avg_valid_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_count_o <= '0;
      max_count_o  <= '0;
      alarm_o      <= 1'b0;
      new_data_o   <= 1'b0;
      missed_o     <= 1'b0;
    end else begin
      if (count_valid_in) last_count_o <= count_in;

      // Ack clears first, then a same-cycle sample is applied on top.
      if (rd_ack_in && count_valid_in)                  max_count_o <= count_in;
      else if (rd_ack_in)                               max_count_o <= '0;
      else if (count_valid_in && count_in > max_count_o) max_count_o <= count_in;

      // Set wins over clear, so overlapping thresholds degrade to a plain compare.
      if (count_valid_in) begin
        if (count_in >= thresh_hi_in)      alarm_o <= 1'b1;
        else if (count_in <= thresh_lo_in) alarm_o <= 1'b0;
      end

      if (count_valid_in) new_data_o <= 1'b1;
      else if (rd_ack_in) new_data_o <= 1'b0;

      if (rd_ack_in)                        missed_o <= 1'b0;
      else if (count_valid_in && new_data_o) missed_o <= 1'b1;
    end
  end

`ifdef TIMED_COUNT_MONITOR_MIN_EN
  localparam logic [CNT_WIDTH-1:0] MIN_RESET = CNT_WIDTH'(CNT_ALL_ONES);

  always_ff @(posedge clk) begin
    if (rst) begin
      min_count_o <= MIN_RESET;
    end else if (rd_ack_in && count_valid_in) begin
      min_count_o <= count_in;
    end else if (rd_ack_in) begin
      min_count_o <= MIN_RESET;
    end else if (count_valid_in && count_in < min_count_o) begin
      min_count_o <= count_in;
    end
  end
`else
  assign min_count_o = '0;
`endif

endmodule

// File: tb/tb_timed_count_monitor.sv
// Directed self-checking bench for timed_count_monitor (CNT_WIDTH=25, AVG_LOG2=3).
module tb_timed_count_monitor;

  localparam int W = 25;
  localparam logic [31:0] ALL_ONES = 32'h01FF_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] count_in;
  logic         count_valid_in;
  logic [W-1:0] thresh_hi_in;
  logic [W-1:0] thresh_lo_in;
  logic         rd_ack_in;
  logic [W-1:0] last_count_o;
  logic [W-1:0] avg_count_o;
  logic         avg_valid_o;
  logic [W-1:0] max_count_o;
  logic [W-1:0] min_count_o;
  logic         alarm_o;
  logic         new_data_o;
  logic         missed_o;

  int n_checks = 0;
  int n_pass   = 0;

  timed_count_monitor #(.CNT_WIDTH(W), .AVG_LOG2(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .count_in      (count_in),
    .count_valid_in(count_valid_in),
    .thresh_hi_in  (thresh_hi_in),
    .thresh_lo_in  (thresh_lo_in),
    .rd_ack_in     (rd_ack_in),
    .last_count_o  (last_count_o),
    .avg_count_o   (avg_count_o),
    .avg_valid_o   (avg_valid_o),
    .max_count_o   (max_count_o),
    .min_count_o   (min_count_o),
    .alarm_o       (alarm_o),
    .new_data_o    (new_data_o),
    .missed_o      (missed_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  // One cycle of stimulus; outputs are sampled 1 time unit after the edge that consumed it.
  task automatic cycle(input logic v, input logic [W-1:0] c, input logic ack, input logic r);
    @(negedge clk);
    count_valid_in = v;
    count_in       = c;
    rd_ack_in      = ack;
    rst            = r;
    @(posedge clk);
    #1;
    count_valid_in = 1'b0;
    rd_ack_in      = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic sample(input logic [W-1:0] c);
    cycle(1'b1, c, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; count_valid_in = 1'b0; count_in = '0; rd_ack_in = 1'b0;
    thresh_hi_in = W'(100); thresh_lo_in = W'(50);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    check("rst_last", 32'(last_count_o), 0);
    check("rst_avg", 32'(avg_count_o), 0);
    check("rst_avg_valid", 32'(avg_valid_o), 0);
    check("rst_max", 32'(max_count_o), 0);
    check("rst_flags", {29'd0, alarm_o, new_data_o, missed_o}, 0);
`ifdef TIMED_COUNT_MONITOR_MIN_EN
    check("rst_min", 32'(min_count_o), ALL_ONES);
`else
    check("rst_min_off", 32'(min_count_o), 0);
`endif

    // Window 10..80: average 360/8 = 45.
    sample(W'(10));
    check("first_new_data", 32'(new_data_o), 1);
    check("first_missed", 32'(missed_o), 0);
    check("first_last", 32'(last_count_o), 10);
    sample(W'(20));
    check("second_missed", 32'(missed_o), 1);
    for (int i = 3; i <= 7; i++) sample(W'(i * 10));
    check("avg_valid_pre", 32'(avg_valid_o), 0);
    check("avg_pre", 32'(avg_count_o), 0);
    sample(W'(80));
    check("avg_valid_win1", 32'(avg_valid_o), 1);
    check("avg_win1", 32'(avg_count_o), 45);
    check("max_win1", 32'(max_count_o), 80);
    check("last_win1", 32'(last_count_o), 80);

    // Ack with sample 5 in the same cycle.
    cycle(1'b1, W'(5), 1'b1, 1'b0);
    check("ackv_max", 32'(max_count_o), 5);
    check("ackv_new_data", 32'(new_data_o), 1);
    check("ackv_missed", 32'(missed_o), 0);

    // Hysteretic alarm, hi=100 lo=50.
    sample(W'(120));
    check("alarm_120", 32'(alarm_o), 1);
    check("max_120", 32'(max_count_o), 120);
    sample(W'(70));
    check("alarm_70", 32'(alarm_o), 1);
    sample(W'(40));
    check("alarm_40", 32'(alarm_o), 0);
    check("missed_after_run", 32'(missed_o), 1);

    // Overlapping thresholds: set priority makes the alarm a plain >= hi compare.
    thresh_hi_in = W'(50); thresh_lo_in = W'(60);
    sample(W'(55));
    check("alarm_ovl_55", 32'(alarm_o), 1);
    sample(W'(45));
    check("alarm_ovl_45", 32'(alarm_o), 0);
    thresh_hi_in = W'(100); thresh_lo_in = W'(50);

    // Ack alone clears peak and sticky flags.
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("ack_max", 32'(max_count_o), 0);
    check("ack_new_data", 32'(new_data_o), 0);
    check("ack_missed", 32'(missed_o), 0);

    // Full-scale window: must not overflow.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) sample(W'(ALL_ONES));
    check("avg_fullscale", 32'(avg_count_o), ALL_ONES);
    check("avg_valid_fullscale", 32'(avg_valid_o), 1);
    check("max_fullscale", 32'(max_count_o), ALL_ONES);

    // Partial window then reset (with a valid in the reset cycle, which must be ignored).
    for (int i = 0; i < 5; i++) sample(W'(1000));
    cycle(1'b1, W'(999), 1'b0, 1'b1);
    check("midrst_avg_valid", 32'(avg_valid_o), 0);
    check("midrst_avg", 32'(avg_count_o), 0);
    check("midrst_last", 32'(last_count_o), 0);
    check("midrst_new_data", 32'(new_data_o), 0);
    for (int i = 0; i < 7; i++) sample(W'(7));
    check("postrst_avg_valid_7", 32'(avg_valid_o), 0);
    sample(W'(7));
    check("postrst_avg_valid_8", 32'(avg_valid_o), 1);
    check("postrst_avg", 32'(avg_count_o), 7);

    // Zero is a legal sample: window of zeros averages to zero and clears the alarm.
    sample(W'(150));
    check("alarm_150", 32'(alarm_o), 1);
    for (int i = 0; i < 8; i++) sample('0);
    check("alarm_zero", 32'(alarm_o), 0);
    check("last_zero", 32'(last_count_o), 0);

`ifdef TIMED_COUNT_MONITOR_MIN_EN
    cycle(1'b0, '0, 1'b0, 1'b1);
    sample(W'(30));
    sample(W'(10));
    sample(W'(20));
    check("min_before_ack", 32'(min_count_o), 10);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("min_after_ack", 32'(min_count_o), ALL_ONES);
    sample(W'(40));
    check("min_after_40", 32'(min_count_o), 40);
    cycle(1'b1, W'(90), 1'b1, 1'b0);
    check("min_ackv", 32'(min_count_o), 90);
`else
    check("min_off_end", 32'(min_count_o), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timed_count_monitor.md
Name: timed_count_monitor

Overview:
- Downstream consumer of the DSP timed counter running in free-running (NORMAL) mode.
- Takes each per-interval count and its 1-cycle valid flag, and produces:
  - last count, power-of-2 boxcar average, peak-since-read;
  - hysteretic rate alarm;
  - sticky new-data/missed flags with read-acknowledge handshake for the register interface.
- Single clock domain. Sits between the counter and the housekeeping register bank.

Parameters:
- CNT_WIDTH, 25, width of incoming count (24-bit interval counter + carry bit).
- AVG_LOG2, 3, log2 of boxcar window length (window = 2^AVG_LOG2 intervals); legal 1..8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- count_in  in  CNT_WIDTH  interval count; sampled only when count_valid_in=1.
- count_valid_in  in  1  1-cycle flag, one per completed interval.
- thresh_hi_in  in  CNT_WIDTH  alarm set threshold (quasi-static).
- thresh_lo_in  in  CNT_WIDTH  alarm clear threshold (quasi-static).
- rd_ack_in  in  1  1-cycle read acknowledge from register bank.
- last_count_o  out  CNT_WIDTH  most recent count.
- avg_count_o  out  CNT_WIDTH  most recent completed window average.
- avg_valid_o  out  1  high once the first full window has completed.
- max_count_o  out  CNT_WIDTH  peak count since last rd_ack_in.
- min_count_o  out  CNT_WIDTH  minimum count since last rd_ack_in (optional feature).
- alarm_o  out  1  hysteretic rate alarm.
- new_data_o  out  1  sticky: a count arrived since last ack.
- missed_o  out  1  sticky: a count arrived while new_data_o was already set.

Behaviour:
- Reset values:
  - all count outputs 0; min_count_o all-ones when the optional feature is enabled;
  - avg_valid_o, alarm_o, new_data_o, missed_o all 0;
  - window counter 0, accumulator 0, state FILL.
- last_count_o: registers count_in one cycle after count_valid_in.
- Accumulator:
  - width CNT_WIDTH+AVG_LOG2; cannot overflow.
  - Window counter is AVG_LOG2 bits and wraps naturally.
  - On valid with window counter != all-ones: acc <= acc + count_in.
  - On valid with window counter == all-ones: avg_count_o <= (acc + count_in) >> AVG_LOG2 (truncating), and acc <= 0, in the same cycle.
  - Latency from the last sample's valid to avg_count_o update: 1 cycle.
- State machine:
  - FILL: avg_valid_o=0. First window completion moves to RUN and sets avg_valid_o in the same cycle avg_count_o updates.
  - RUN: avg_valid_o=1. Stays in RUN until rst.
- Peak (max_count_o):
  - On valid: max <= (count_in > max) ? count_in : max.
  - On rd_ack_in alone: max <= 0.
  - On rd_ack_in and valid in the same cycle: max <= count_in (ack clears, then the sample is applied).
- Alarm, evaluated on valid against count_in:
  - set when count_in >= thresh_hi_in;
  - else clear when count_in <= thresh_lo_in;
  - else hold.
  - Set has priority, so with thresh_lo_in >= thresh_hi_in the alarm tracks count_in >= thresh_hi_in.
  - Updates 1 cycle after valid.
- Handshake:
  - new_data_o is set by valid and cleared by rd_ack_in.
  - valid while new_data_o=1 and no ack: missed_o <= 1.
  - rd_ack_in clears missed_o.
  - ack and valid in the same cycle: new_data_o=1, missed_o=0.
- Mid-operation rst: discards the partial window and returns to FILL. A valid in the reset cycle is ignored.
- count_in of 0 is a legal sample: it is accumulated and compared normally.

Optional Feature:
- Macro: TIMED_COUNT_MONITOR_MIN_EN.
- Defined: min_count_o tracks the minimum since last ack, using the same rules as max:
  - reset and ack value is all-ones;
  - ack and valid in the same cycle: min <= count_in.
- Undefined: min_count_o is constant 0 and no min register is synthesized.

Decomposition:
- Shared package (timed_count_pkg):
  - CNT_WIDTH default constant;
  - FILL/RUN state enum typedef;
  - all-ones constant for the min reset value.
- One sub-module, count_boxcar_avg, owns:
  - window counter, accumulator, FILL/RUN state;
  - avg_count_o and avg_valid_o.
- Top level holds last/max/min/alarm/handshake registers.

Test Plan (AVG_LOG2=3):
- Reset, then 8 valids with counts 10,20,...,80, no ack:
  - avg_valid_o rises 1 cycle after the 8th valid;
  - avg_count_o=45; max_count_o=80; missed_o=1 after the 2nd valid.
- thresh_hi=100, thresh_lo=50; counts 120, 70, 40:
  - alarm_o = 1 after 120, stays 1 after 70, drops to 0 after 40.
- Same-cycle rd_ack_in and valid with count 5, previous max 80:
  - max_count_o=5; new_data_o=1; missed_o=0.
- Counts 2^25-1 ×8:
  - avg_count_o=2^25-1; no accumulator overflow.
- 5 valids, then rst, then 8 valids of 7:
  - avg_valid_o low until the 8th post-reset valid; avg_count_o=7.
- With TIMED_COUNT_MONITOR_MIN_EN, counts 30,10,20, then ack, then 40:
  - min_count_o=10 before the ack, all-ones after the ack, 40 after the final count.
